// File: rtl/servo_ramp_ctrl_pkg.sv
// Shared definitions for the servo ramp controller: register map, CTRL/STATUS bit
// positions, FSM state encoding and the pulse-width arithmetic helpers.
package servo_ramp_ctrl_pkg;

  localparam logic [7:0] ADDR_TARGET  = 8'h00;
  localparam logic [7:0] ADDR_STEP    = 8'h04;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h0C;
  localparam logic [7:0] ADDR_CURRENT = 8'h10;
  localparam logic [7:0] ADDR_IRQ_CLR = 8'h14;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam logic [31:0] STEP_RESET = 32'd1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  function automatic logic [31:0] clamp_pw(input logic [31:0] v, input logic [31:0] lo,
                                           input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // One frame's move: land exactly on the target when within one step of it.
  function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [31:0] diff;
    diff = (tgt >= cur) ? tgt - cur : cur - tgt;
    if (diff <= step) return tgt;
    return (tgt > cur) ? cur + step : cur - step;
  endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Peripheral bus between the bus decoder (master) and the servo ramp controller (slave).
interface servo_ramp_ctrl_if;
  logic        bus_write_en;
  logic        bus_read_en;
  logic        ctrl_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;

  modport master (
    output bus_write_en, bus_read_en, ctrl_en, bus_addr, bus_write_data,
    input  bus_read_data
  );

  modport slave (
    input  bus_write_en, bus_read_en, ctrl_en, bus_addr, bus_write_data,
    output bus_read_data
  );
endinterface

// File: rtl/servo_ramp_ctrl_frame_timer.sv
// Free-running PWM frame timer: counts 0..PERIOD_CYCLES-1 and flags the last cycle.
module servo_frame_timer #(
  parameter int unsigned PERIOD_CYCLES = 2000000
) (
  input  logic pclk,
  input  logic reset,
  output logic tick
);
  localparam int W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD_CYCLES - 1);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + W'(1);
  end

  assign tick = (count == LAST);
endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo ramp sequencer: slews the PWM compare value toward TARGET once per frame, then
// settles and reports done/timeout. Define SERVO_CTRL_IRQ_EN to add the irq port and IRQ_CLR.
module servo_ramp_ctrl
  import servo_ramp_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = 2000000,
  parameter int unsigned MIN_PW        = 50000,
  parameter int unsigned MAX_PW        = 250000,
  parameter int unsigned PARK_PW       = 150000,
  parameter int unsigned SETTLE_FRAMES = 10,
  parameter int unsigned MAX_FRAMES    = 200
) (
  input  logic             pclk,
  input  logic             reset,
  servo_ramp_ctrl_if.slave bus,
  output logic             pw_wr_en,
  output logic [31:0]      pw_data,
  output logic             busy
`ifdef SERVO_CTRL_IRQ_EN
  ,
  output logic             irq
`endif
);
  localparam logic [31:0] MIN_PW_W  = 32'(MIN_PW);
  localparam logic [31:0] MAX_PW_W  = 32'(MAX_PW);
  localparam logic [31:0] PARK_PW_W = 32'(PARK_PW);
  localparam logic [31:0] SETTLE_W  = 32'(SETTLE_FRAMES);
  localparam logic [31:0] MAX_FR_W  = 32'(MAX_FRAMES);

  logic        tick;
  state_t      state;
  logic [31:0] target_q, step_q, current_q, frame_cnt, settle_cnt;
  logic        done_q, timeout_q, park_pending;
  logic        wr_access, start, abort, target_moved, frame_last, settle_last;
  logic [31:0] step_eff, next_cur, status_word;

  servo_frame_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_frame_timer (
    .pclk  (pclk),
    .reset (reset),
    .tick  (tick)
  );

  assign wr_access    = bus.bus_write_en & bus.ctrl_en;
  assign abort        = wr_access && (bus.bus_addr == ADDR_CTRL) && bus.bus_write_data[CTRL_ABORT_BIT];
  assign start        = wr_access && (bus.bus_addr == ADDR_CTRL) && bus.bus_write_data[CTRL_START_BIT]
                        && !abort;
  assign step_eff     = (step_q == '0) ? 32'd1 : step_q;
  assign next_cur     = step_toward(current_q, target_q, step_eff);
  assign target_moved = (target_q != current_q);
  assign frame_last   = (frame_cnt + 32'd1 == MAX_FR_W);
  assign settle_last  = (settle_cnt + 32'd1 == SETTLE_W);
  assign busy         = (state != ST_IDLE);
  assign pw_data      = current_q;
  assign status_word  = {27'd0, state, timeout_q, done_q, busy};

  // TARGET is clamped on the way in, so CURRENT can never leave the legal range.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      target_q <= PARK_PW_W;
      step_q   <= STEP_RESET;
    end else if (wr_access) begin
      case (bus.bus_addr)
        ADDR_TARGET: target_q <= clamp_pw(bus.bus_write_data, MIN_PW_W, MAX_PW_W);
        ADDR_STEP:   step_q   <= bus.bus_write_data;
        default:     ;
      endcase
    end
  end

  // NOTE: the default assignment ahead of the case keeps this always_comb latch-free.
  always_comb begin
    bus.bus_read_data = '0;
    if (bus.bus_read_en && bus.ctrl_en) begin
      case (bus.bus_addr)
        ADDR_TARGET:  bus.bus_read_data = target_q;
        ADDR_STEP:    bus.bus_read_data = step_q;
        ADDR_STATUS:  bus.bus_read_data = status_word;
        ADDR_CURRENT: bus.bus_read_data = current_q;
        default:      bus.bus_read_data = '0;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      current_q    <= PARK_PW_W;
      frame_cnt    <= '0;
      settle_cnt   <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      pw_wr_en     <= 1'b0;
      park_pending <= 1'b1;
    end else begin
      // The first frame after reset re-sends the park position to the servo.
      pw_wr_en <= tick & park_pending;
      if (tick) park_pending <= 1'b0;

      if (abort) begin
        state <= ST_IDLE;
      end else if (start) begin
        state     <= ST_RAMP;
        frame_cnt <= '0;
        if (state == ST_IDLE) begin
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
        end
      end else begin
        case (state)
          ST_RAMP: if (tick) begin
            current_q <= next_cur;
            pw_wr_en  <= 1'b1;
            frame_cnt <= frame_cnt + 32'd1;
            if (frame_last) begin
              state     <= ST_IDLE;
              timeout_q <= 1'b1;
            end else if (next_cur == target_q) begin
              state      <= ST_SETTLE;
              settle_cnt <= '0;
            end
          end
          ST_SETTLE: begin
            if (target_moved) begin
              state <= ST_RAMP;
            end else if (tick) begin
              settle_cnt <= settle_cnt + 32'd1;
              frame_cnt  <= frame_cnt + 32'd1;
              if (settle_last) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end else if (frame_last) begin
                state     <= ST_IDLE;
                timeout_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SERVO_CTRL_IRQ_EN
  logic irq_set, irq_clr;

  // Mirrors the FSM conditions that raise done or timeout on this edge.
  assign irq_set = tick && !abort && !start &&
                   (((state == ST_RAMP) && frame_last) ||
                    ((state == ST_SETTLE) && !target_moved && (settle_last || frame_last)));
  assign irq_clr = wr_access && (bus.bus_addr == ADDR_IRQ_CLR) && bus.bus_write_data[0];

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_set | (irq & ~irq_clr);
  end
`endif

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with a short frame (100 cycles), 2 settle frames, 20 max frames.
`timescale 1ns/1ps
module tb_servo_ramp_ctrl;
  import servo_ramp_ctrl_pkg::*;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        pw_wr_en;
  logic [31:0] pw_data;
  logic        busy;
`ifdef SERVO_CTRL_IRQ_EN
  logic        irq;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] wr_log[$];

  servo_ramp_ctrl_if bus_if();

  servo_ramp_ctrl #(
    .PERIOD_CYCLES (100),
    .SETTLE_FRAMES (2),
    .MAX_FRAMES    (20)
  ) dut (
    .pclk     (pclk),
    .reset    (reset),
    .bus      (bus_if.slave),
    .pw_wr_en (pw_wr_en),
    .pw_data  (pw_data),
    .busy     (busy)
`ifdef SERVO_CTRL_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (pw_wr_en === 1'b1) wr_log.push_back(pw_data);

  task automatic bus_idle();
    bus_if.bus_write_en   = 1'b0;
    bus_if.bus_read_en    = 1'b0;
    bus_if.ctrl_en        = 1'b0;
    bus_if.bus_addr       = '0;
    bus_if.bus_write_data = '0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge pclk);
    bus_if.bus_write_en = 1'b1; bus_if.ctrl_en = 1'b1;
    bus_if.bus_addr = a; bus_if.bus_write_data = d;
    @(negedge pclk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge pclk);
    bus_if.bus_read_en = 1'b1; bus_if.ctrl_en = 1'b1; bus_if.bus_addr = a;
    #1 d = bus_if.bus_read_data;
    bus_idle();
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pclk); #1;
      if (wr_log.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pclk); #1;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic apply_reset();
    bus_idle();
    reset = 1'b1;
    repeat (3) @(negedge pclk);
    reset = 1'b0;
    wr_log.delete();
  endtask

  task automatic reset_and_park();
    bit ok;
    apply_reset();
    wait_writes(1, 150, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL park_wait: got no pw write expected one"); end
    wr_log.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bit ok;
    bus_idle();
    reset = 1'b1;
    repeat (2) @(negedge pclk);
    n_cmp++; if (pw_data !== 32'd150000) begin n_bad++; $display("FAIL reset_pw_data: got %0d expected 150000", pw_data); end
    n_cmp++; if ({pw_wr_en, busy} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b expected 00", {pw_wr_en, busy}); end
    @(negedge pclk);
    reset = 1'b0;
    wr_log.delete();
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h expected 0", rd); end
    bus_read(ADDR_TARGET, rd);
    n_cmp++; if (rd !== 32'd150000) begin n_bad++; $display("FAIL reset_target: got %0d expected 150000", rd); end
    bus_read(ADDR_STEP, rd);
    n_cmp++; if (rd !== 32'd1000) begin n_bad++; $display("FAIL reset_step: got %0d expected 1000", rd); end
    bus_read(ADDR_CURRENT, rd);
    n_cmp++; if (rd !== 32'd150000) begin n_bad++; $display("FAIL reset_current: got %0d expected 150000", rd); end
    bus_read(8'h20, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h expected 0", rd); end
    bus_read(ADDR_IRQ_CLR, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL irq_clr_read: got %h expected 0", rd); end
    // Read strobe without block select must return zero.
    @(negedge pclk);
    bus_if.bus_read_en = 1'b1; bus_if.ctrl_en = 1'b0; bus_if.bus_addr = ADDR_TARGET;
    #1 rd = bus_if.bus_read_data;
    bus_idle();
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unselected_read: got %h expected 0", rd); end
    wait_writes(1, 150, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL park_timeout: got no pw write expected one"); end
    repeat (120) @(negedge pclk);
    #1;
    n_cmp++; if (wr_log.size() !== 1) begin n_bad++; $display("FAIL park_count: got %0d expected 1", wr_log.size()); end
    n_cmp++; if (wr_log[0] !== 32'd150000) begin n_bad++; $display("FAIL park_value: got %0d expected 150000", wr_log[0]); end
  endtask

  task automatic test_ramp_basic();
    logic [31:0] rd;
    logic [31:0] exp_w[3] = '{32'd154000, 32'd158000, 32'd160000};
    bit ok;
    time t3, t_idle;
    wr_log.delete();
    bus_write(ADDR_TARGET, 32'd160000);
    bus_write(ADDR_STEP, 32'd4000);
    bus_write(ADDR_CTRL, 32'h1);
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h09) begin n_bad++; $display("FAIL ramp_status: got %h expected 09", rd); end
    wait_writes(3, 400, ok);
    t3 = $time;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ramp_wait: got %0d writes expected 3", wr_log.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (wr_log[i] !== exp_w[i]) begin n_bad++; $display("FAIL ramp_write%0d: got %0d expected %0d", i, wr_log[i], exp_w[i]); end
    end
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h11) begin n_bad++; $display("FAIL settle_status: got %h expected 11", rd); end
    wait_idle(300, ok);
    t_idle = $time;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL settle_wait: busy stuck expected idle"); end
    n_cmp++; if ((t_idle - t3) !== 64'd2000) begin n_bad++; $display("FAIL settle_time: got %0d ns expected 2000 ns", t_idle - t3); end
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h02) begin n_bad++; $display("FAIL done_status: got %h expected 02", rd); end
    n_cmp++; if (wr_log.size() !== 3) begin n_bad++; $display("FAIL ramp_count: got %0d expected 3", wr_log.size()); end
  endtask

  task automatic test_clamp();
    logic [31:0] rd;
    bit ok;
    wr_log.delete();
    bus_write(ADDR_STEP, 32'd100000);
    bus_write(ADDR_TARGET, 32'd10);
    bus_read(ADDR_TARGET, rd);
    n_cmp++; if (rd !== 32'd50000) begin n_bad++; $display("FAIL clamp_low_target: got %0d expected 50000", rd); end
    bus_write(ADDR_CTRL, 32'h1);
    wait_idle(600, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL clamp_low_wait: busy stuck expected idle"); end
    bus_read(ADDR_CURRENT, rd);
    n_cmp++; if (rd !== 32'd50000) begin n_bad++; $display("FAIL clamp_low_current: got %0d expected 50000", rd); end
    n_cmp++; if (wr_log.size() !== 2 || wr_log[0] !== 32'd60000) begin n_bad++; $display("FAIL clamp_low_writes: got %0d first %0d expected 2 first 60000", wr_log.size(), wr_log[0]); end
    wr_log.delete();
    bus_write(ADDR_TARGET, 32'hFFFF_FFFF);
    bus_read(ADDR_TARGET, rd);
    n_cmp++; if (rd !== 32'd250000) begin n_bad++; $display("FAIL clamp_high_target: got %0d expected 250000", rd); end
    bus_write(ADDR_CTRL, 32'h1);
    wait_idle(600, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL clamp_high_wait: busy stuck expected idle"); end
    bus_read(ADDR_CURRENT, rd);
    n_cmp++; if (rd !== 32'd250000) begin n_bad++; $display("FAIL clamp_high_current: got %0d expected 250000", rd); end
    n_cmp++; if (wr_log.size() !== 2 || wr_log[0] !== 32'd150000) begin n_bad++; $display("FAIL clamp_high_writes: got %0d first %0d expected 2 first 150000", wr_log.size(), wr_log[0]); end
  endtask

  task automatic test_step_zero();
    logic [31:0] rd;
    bit ok;
    reset_and_park();
    bus_write(ADDR_STEP, 32'd0);
    bus_write(ADDR_TARGET, 32'd150005);
    bus_write(ADDR_CTRL, 32'h1);
    bus_read(ADDR_STEP, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL step_zero_readback: got %0d expected 0", rd); end
    wait_idle(1000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL step_zero_wait: busy stuck expected idle"); end
    n_cmp++; if (wr_log.size() !== 5) begin n_bad++; $display("FAIL step_zero_count: got %0d expected 5", wr_log.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (wr_log[i] !== 32'd150001 + 32'(i)) begin n_bad++; $display("FAIL step_zero_write%0d: got %0d expected %0d", i, wr_log[i], 150001 + i); end
    end
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h02) begin n_bad++; $display("FAIL step_zero_status: got %h expected 02", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    bit ok;
    reset_and_park();
    bus_write(ADDR_STEP, 32'd1000);
    bus_write(ADDR_TARGET, 32'd200000);
    bus_write(ADDR_CTRL, 32'h1);
    wait_writes(2, 250, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL abort_pre_wait: got %0d writes expected 2", wr_log.size()); end
    bus_write(ADDR_CTRL, 32'h3);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL abort_status: got %h expected 0", rd); end
    repeat (300) @(negedge pclk);
    bus_read(ADDR_CURRENT, rd);
    n_cmp++; if (rd !== 32'd152000) begin n_bad++; $display("FAIL abort_current: got %0d expected 152000", rd); end
    n_cmp++; if (wr_log.size() !== 2) begin n_bad++; $display("FAIL abort_writes: got %0d expected 2", wr_log.size()); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    bit ok;
    reset_and_park();
    bus_write(ADDR_STEP, 32'd1);
    bus_write(ADDR_TARGET, 32'd250000);
    bus_write(ADDR_CTRL, 32'h1);
    wait_idle(2500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL timeout_wait: busy stuck expected idle"); end
    bus_read(ADDR_STATUS, rd);
    n_cmp++; if (rd !== 32'h04) begin n_bad++; $display("FAIL timeout_status: got %h expected 04", rd); end
    bus_read(ADDR_CURRENT, rd);
    n_cmp++; if (rd !== 32'd150020) begin n_bad++; $display("FAIL timeout_current: got %0d expected 150020", rd); end
    n_cmp++; if (wr_log.size() !== 20) begin n_bad++; $display("FAIL timeout_writes: got %0d expected 20", wr_log.size()); end
`ifdef SERVO_CTRL_IRQ_EN
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b expected 1", irq); end
    bus_write(ADDR_IRQ_CLR, 32'h1);
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b expected 0", irq); end
`endif
  endtask

  initial begin
    test_reset();
    test_ramp_basic();
    test_clamp();
    test_step_zero();
    test_abort();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
